// File: rtl/ws2811_transmitter.sv
// WS2811 serial output stage: fetches each pixel from the colour controller and
// drives it out as 24 GRB bits with NRZ pulse-width timing, then a latch period.
module ws2811_transmitter #(
  parameter int NUM_LEDS     = 50,
  parameter int BIT_CYCLES   = 62,
  parameter int T0H_CYCLES   = 20,
  parameter int T1H_CYCLES   = 40,
  parameter int RESET_CYCLES = 2600,
  parameter int FETCH_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic [7:0] ledindex,
  output logic       dout,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

  localparam logic [7:0]  LAST_LED   = 8'(NUM_LEDS - 1);
  localparam logic [15:0] BIT_LAST   = 16'(BIT_CYCLES - 1);
  localparam logic [15:0] FETCH_LAST = 16'(FETCH_CYCLES - 1);
  localparam logic [15:0] RESET_LAST = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] T0H        = 16'(T0H_CYCLES);
  localparam logic [15:0] T1H        = 16'(T1H_CYCLES);

  state_t      state;
  logic [15:0] cyc_cnt;    // fetch, bit-cycle or latch count depending on state
  logic [4:0]  bit_cnt;
  logic [15:0] pf_cnt;
  logic        pf_busy;    // prefetch settle window running
  logic        next_valid; // another pixel follows the one being sent
  logic [23:0] shift_q;
  logic [23:0] hold_q;

  logic [23:0] pixel;
  logic [15:0] high_len;

  always_comb begin
    pixel    = {green, red, blue};
    high_len = shift_q[23] ? T1H : T0H;
  end

  // NOTE: every register here is assigned with <= so all of them update from the
  // same pre-edge values; a blocking = would let later statements see new values.
  // NOTE: the pixel shift/hold registers are reset too, so a frame aborted by
  // rst_n can never leak stale colour data into the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      pf_cnt     <= '0;
      pf_busy    <= 1'b0;
      next_valid <= 1'b0;
      shift_q    <= '0;
      hold_q     <= '0;
      ledindex   <= '0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          dout <= 1'b0;
          busy <= 1'b0;
          if (enable) begin
            state    <= FETCH;
            busy     <= 1'b1;
            ledindex <= '0;
            cyc_cnt  <= '0;
          end
        end

        FETCH: begin
          dout <= 1'b0;
          if (cyc_cnt == FETCH_LAST) begin
            shift_q <= pixel;
            state   <= SEND;
            cyc_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end

        SEND: begin
          dout <= (cyc_cnt < high_len);

          // Request the next pixel as soon as this one starts, so its colour has
          // settled well before the current 24 bits run out.
          if (bit_cnt == 5'd0 && cyc_cnt == 16'd0 && ledindex != LAST_LED) begin
            ledindex   <= ledindex + 8'd1;
            pf_cnt     <= '0;
            pf_busy    <= 1'b1;
            next_valid <= 1'b1;
          end else if (pf_busy) begin
            if (pf_cnt == FETCH_LAST) begin
              hold_q  <= pixel;
              pf_busy <= 1'b0;
            end else begin
              pf_cnt <= pf_cnt + 16'd1;
            end
          end

          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= '0;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              if (next_valid) begin
                shift_q    <= hold_q;
                next_valid <= 1'b0;
              end else begin
                state <= LATCH;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              shift_q <= {shift_q[22:0], 1'b0};
            end
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end

        LATCH: begin
          dout <= 1'b0;
          if (cyc_cnt == RESET_LAST) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            ledindex   <= '0;
            cyc_cnt    <= '0;
            state      <= IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2811_transmitter.sv
// Directed bench for ws2811_transmitter: decodes dout pulse widths back into GRB
// words and checks frame timing, ledindex stepping, enable and reset behaviour.
module tb_ws2811_transmitter;

  localparam int BIT   = 10;
  localparam int T0H   = 3;
  localparam int T1H   = 7;
  localparam int RST   = 20;
  localparam int FETCH = 16;
  localparam int MAXN  = 2400;

  // Sample index (after the enable-sampling edge) of key events.
  localparam int FIRST_HIGH = FETCH + 1;
  localparam int FD1        = FIRST_HIGH + 24 * BIT + RST - 1;
  localparam int FD3        = FIRST_HIGH + 72 * BIT + RST - 1;
  localparam int PERIOD3    = FD3 + 1;

  logic       clk;
  logic       rst_n;
  logic       en1, en3;
  logic [7:0] r1, g1, b1;
  logic [7:0] li1, li3;
  logic       dout1, busy1, fd1;
  logic       dout3, busy3, fd3;

  ws2811_transmitter #(
    .NUM_LEDS(1), .BIT_CYCLES(BIT), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
    .RESET_CYCLES(RST), .FETCH_CYCLES(FETCH)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .red(r1), .green(g1), .blue(b1),
    .ledindex(li1), .dout(dout1), .busy(busy1), .frame_done(fd1)
  );

  // Stub controller: red follows the requested index, green and blue zero.
  ws2811_transmitter #(
    .NUM_LEDS(3), .BIT_CYCLES(BIT), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
    .RESET_CYCLES(RST), .FETCH_CYCLES(FETCH)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(en3), .red(li3), .green(8'h00), .blue(8'h00),
    .ledindex(li3), .dout(dout3), .busy(busy3), .frame_done(fd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Captured waveform and analysis results.
  logic        cap_d  [MAXN];
  logic        cap_fd [MAXN];
  logic        cap_bz [MAXN];
  logic [7:0]  cap_li [MAXN];
  logic [23:0] words[$];
  int          fd_idx[$];
  int          n_bits, bad_pulses, first_high, max_gap, min_frame_gap;

  function automatic logic [23:0] word_at(input int k);
    return (k < words.size()) ? words[k] : 24'hxxxxxx;
  endfunction

  function automatic int fd_at(input int k);
    return (k < fd_idx.size()) ? fd_idx[k] : -1;
  endfunction

  function automatic void analyse(input int n);
    int h = 0, last_fall = -1;
    bit fd_seen = 0;
    logic [23:0] w = '0;
    words.delete();
    fd_idx.delete();
    n_bits = 0; bad_pulses = 0; first_high = -1; max_gap = 0; min_frame_gap = 1 << 30;
    for (int i = 0; i < n; i++) begin
      if (cap_fd[i]) begin
        fd_idx.push_back(i);
        fd_seen = 1;
      end
      if (cap_d[i]) begin
        if (h == 0) begin
          if (first_high < 0) first_high = i;
          if (last_fall >= 0) begin
            if (fd_seen) begin
              if (i - last_fall < min_frame_gap) min_frame_gap = i - last_fall;
            end else if (i - last_fall > max_gap) begin
              max_gap = i - last_fall;
            end
          end
          fd_seen = 0;
        end
        h++;
      end else if (h > 0) begin
        if (h == T0H || h == T1H) begin
          w = {w[22:0], (h == T1H)};
          n_bits++;
          if (n_bits % 24 == 0) words.push_back(w);
        end else begin
          bad_pulses++;
        end
        h = 0;
        last_fall = i;
      end
    end
  endfunction

  // Called on the negedge right after the enable-sampling edge: sample i is the
  // state after that edge plus i clocks. Enable drops after sample drop_at.
  task automatic capture(input int sel, input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      cap_d[i]  = (sel == 1) ? dout1 : dout3;
      cap_fd[i] = (sel == 1) ? fd1   : fd3;
      cap_bz[i] = (sel == 1) ? busy1 : busy3;
      cap_li[i] = (sel == 1) ? li1   : li3;
      if (i == drop_at) begin
        if (sel == 1) en1 = 1'b0;
        else          en3 = 1'b0;
      end
    end
    analyse(n);
  endtask

  task automatic frame3(input string tag);
    @(negedge clk);
    en3 = 1'b1;
    @(negedge clk);
    capture(3, FD3 + 20, 0);
    check({tag, "_first_high"}, first_high, FIRST_HIGH);
    check({tag, "_li_before"}, cap_li[FIRST_HIGH - 1], 0);
    check({tag, "_li_step1"}, cap_li[FIRST_HIGH], 1);
    check({tag, "_li_hold1"}, cap_li[FIRST_HIGH + 24 * BIT - 1], 1);
    check({tag, "_li_step2"}, cap_li[FIRST_HIGH + 24 * BIT], 2);
    check({tag, "_li_last"}, cap_li[FD3 - 1], 2);
    check({tag, "_li_after"}, cap_li[FD3], 0);
    check({tag, "_nbits"}, n_bits, 72);
    check({tag, "_bad"}, bad_pulses, 0);
    check({tag, "_w0"}, word_at(0), 24'h000000);
    check({tag, "_w1"}, word_at(1), 24'h000100);
    check({tag, "_w2"}, word_at(2), 24'h000200);
    check({tag, "_gap"}, max_gap, BIT - T0H);
    check({tag, "_fd_cnt"}, fd_idx.size(), 1);
    check({tag, "_fd_at"}, fd_at(0), FD3);
  endtask

  initial begin
    int li_bad;
    int waited;

    // Reset held with enable high: everything quiet.
    rst_n = 1'b0; en1 = 1'b1; en3 = 1'b1;
    g1 = 8'h01; r1 = 8'h80; b1 = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_quiet", {dout1, busy1, fd1, li1, dout3, busy3, fd3, li3}, 0);
    end
    en1 = 1'b0; en3 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_quiet", {dout1, busy1, fd3, busy3}, 0);

    // Single pixel frame, G=01 R=80 B=FF.
    en1 = 1'b1;
    @(negedge clk);
    capture(1, FD1 + 20, 0);
    check("p1_busy_start", cap_bz[0], 1);
    check("p1_first_high", first_high, FIRST_HIGH);
    check("p1_nbits", n_bits, 24);
    check("p1_bad", bad_pulses, 0);
    check("p1_word", word_at(0), 24'h0180FF);
    check("p1_fd_cnt", fd_idx.size(), 1);
    check("p1_fd_at", fd_at(0), FD1);
    check("p1_busy_before_fd", cap_bz[FD1 - 1], 1);
    check("p1_busy_at_fd", cap_bz[FD1], 0);
    check("p1_latch_low", cap_d[FD1 - RST + 1] | cap_d[FD1], 0);
    li_bad = 0;
    for (int i = 0; i < FD1 + 20; i++) if (cap_li[i] != 0) li_bad++;
    check("p1_li_static", li_bad, 0);

    // Three pixels with the index stub.
    frame3("p3");

    // Enable dropped during pixel 1: frame still completes, no restart.
    @(negedge clk);
    en3 = 1'b1;
    @(negedge clk);
    capture(3, FD3 + 60, FIRST_HIGH + 24 * BIT + 40);
    check("drop_nbits", n_bits, 72);
    check("drop_w2", word_at(2), 24'h000200);
    check("drop_fd_cnt", fd_idx.size(), 1);
    check("drop_fd_at", fd_at(0), FD3);
    check("drop_busy_end", cap_bz[FD3 + 59], 0);

    // Reset mid-bit while dout is high on pixel 1.
    @(negedge clk);
    en3 = 1'b1;
    @(negedge clk);
    en3 = 1'b0;
    waited = 0;
    while (!(li3 == 8'd2 && dout3 == 1'b1) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("rst_mid_reached", waited < 2000, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_dout", dout3, 0);
    check("rst_mid_state", {busy3, li3}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    frame3("rst_restart");

    // Enable held for three back-to-back frames.
    @(negedge clk);
    en3 = 1'b1;
    @(negedge clk);
    capture(3, 2 * PERIOD3 + FD3 + 30, 2 * PERIOD3 + FD3);
    check("b2b_fd_cnt", fd_idx.size(), 3);
    check("b2b_fd0", fd_at(0), FD3);
    check("b2b_fd1", fd_at(1), PERIOD3 + FD3);
    check("b2b_fd2", fd_at(2), 2 * PERIOD3 + FD3);
    check("b2b_nbits", n_bits, 216);
    check("b2b_bad", bad_pulses, 0);
    for (int f = 0; f < 3; f++) begin
      check("b2b_w0", word_at(3 * f), 24'h000000);
      check("b2b_w1", word_at(3 * f + 1), 24'h000100);
      check("b2b_w2", word_at(3 * f + 2), 24'h000200);
    end
    check("b2b_latch_gap", min_frame_gap >= RST, 1);
    check("b2b_idle_end", cap_bz[2 * PERIOD3 + FD3 + 29], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2811_transmitter.md
Name: ws2811_transmitter

Overview:
- Serial output end of the LED chain. Walks `ledindex` from 0 to NUM_LEDS-1 into the colour/animation controller and samples that pixel's red/green/blue once they have settled.
- Serialises each pixel as 24 bits, GRB order, MSB first, with WS2811 NRZ pulse-width timing on `dout`.
- After the last pixel, holds `dout` low for the latch/reset period and signals frame completion.
- Next pixel is prefetched during the current pixel's transmission, so there is no gap between pixels.

Parameters:
- NUM_LEDS, 50: pixels per frame, 1..256.
- BIT_CYCLES, 62: clk cycles per bit (1.25 us at 50 MHz).
- T0H_CYCLES, 20: high cycles for a 0 bit.
- T1H_CYCLES, 40: high cycles for a 1 bit.
- RESET_CYCLES, 2600: low cycles for the latch (52 us at 50 MHz).
- FETCH_CYCLES, 16: settle cycles after `ledindex` changes before red/green/blue are valid. Covers two full 8-phase controller passes.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  start/continue frames while high
- red  input  8  pixel red from controller
- green  input  8  pixel green from controller
- blue  input  8  pixel blue from controller
- ledindex  output  8  pixel currently requested from controller
- dout  output  1  WS2811 serial data, registered
- busy  output  1  high from frame start until frame_done
- frame_done  output  1  one-cycle pulse at end of latch period

Behaviour:
- Legal configuration: T0H_CYCLES < T1H_CYCLES < BIT_CYCLES; FETCH_CYCLES < 24*BIT_CYCLES. Internal counters are 16 bit.
- Reset (async, rst_n=0):
  - state IDLE;
  - dout=0, ledindex=0, busy=0, frame_done=0;
  - shift and hold registers cleared.
  - Reset asserted mid-frame aborts immediately and `dout` goes low without waiting for a clock edge.
- IDLE:
  - dout=0, busy=0.
  - enable sampled 1 → FETCH; busy=1; ledindex=0; fetch counter=0.
- FETCH (first pixel only):
  - Counts FETCH_CYCLES cycles.
  - On the last cycle, loads the shift register with {green, red, blue} and enters SEND with bit counter 0 and cycle counter 0.
  - First `dout` high appears FETCH_CYCLES+1 clocks after the enable-sampling edge.
- SEND, per bit:
  - dout=1 while cycle counter < (bit ? T1H_CYCLES : T0H_CYCLES), else 0.
  - The cycle counter wraps at BIT_CYCLES-1, then the register shifts left.
  - 24 bits per pixel; exactly 24*BIT_CYCLES cycles per pixel.
- Prefetch:
  - On the first cycle of each pixel's SEND, if ledindex < NUM_LEDS-1, ledindex increments and a prefetch counter restarts.
  - When the prefetch counter reaches FETCH_CYCLES, the hold register captures {green, red, blue}.
  - At the end of bit 23, the hold register loads into the shift register and the next pixel's bit 0 starts on the very next cycle (no idle gap).
- End of last pixel (ledindex == NUM_LEDS-1 at end of bit 23) → LATCH:
  - No prefetch occurs for the last pixel; ledindex holds at NUM_LEDS-1.
- LATCH:
  - dout=0 for RESET_CYCLES cycles.
  - Then frame_done=1 for one cycle, busy=0, ledindex=0, state IDLE.
- enable:
  - Only sampled in IDLE. Deassertion mid-frame does not truncate the frame.
  - enable held high gives back-to-back frames, with one IDLE cycle after frame_done, then FETCH.
- NUM_LEDS=1: no prefetch ever occurs; the frame is FETCH, then 24 bits, then LATCH.
- red/green/blue are only sampled at the defined capture points; changes at other times have no effect.

Test Plan:
1. Assert rst_n=0 with enable=1 → dout=0, ledindex=0, busy=0, frame_done=0 throughout; no activity until release.
2. Config: NUM_LEDS=1, BIT=10, T0H=3, T1H=7, RESET=20, FETCH=16; green=0x01, red=0x80, blue=0xFF; pulse enable.
   - Bits 0–6 each give 3 high / 7 low; bit 7 gives 7 high.
   - Bit 8 gives 7 high, then 7 zero-bits at 3 high each.
   - Blue bits all give 7 high.
   - After bit 23: 20 low cycles, then a single frame_done pulse; busy falls with it.
3. Config: NUM_LEDS=3, same timing; stub controller returns red=ledindex, green=0, blue=0.
   - ledindex steps 0→1 at the start of pixel 0's SEND and 1→2 at the start of pixel 1's SEND.
   - Decoded stream: 000000,000100,000200 (GRB).
   - No low gap longer than one bit's low time between pixels.
4. Same config as 3; drop enable during pixel 1 → all 3 pixels plus latch complete; one frame_done; then IDLE with busy=0 and no further dout activity.
5. Pull rst_n low mid-bit while dout=1 → dout=0 before the next clk edge; after release, the next enable restarts the frame at ledindex=0.
6. Hold enable=1 for 3 frames → exactly 3 frame_done pulses, each followed by RESET_CYCLES+ low time before the next frame's first bit; identical bit streams each frame.
